wave_trigger: RTL and testbench



---
 rtl/wave_trig_pkg.sv | 22 ++
 rtl/wave_trig_ram.sv | 29 ++
 rtl/wave_trigger.sv | 254 +++++++++++++++++++++++++
 tb/tb_wave_trigger.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wave_trig_pkg.sv
// Shared types for the wave_trigger capture stage: FSM states, edge select, pointer width.
// Imported by the top and the capture RAM.
package wave_trig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ARMED,
    ST_POST,
    ST_READ
  } state_e;

  typedef enum logic {
    EDGE_RISING  = 1'b0,
    EDGE_FALLING = 1'b1
  } edge_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/wave_trig_ram.sv
// Simple dual-port DEPTH x N capture RAM: one write port, one registered read port (1-cycle latency).
// No reset on storage or read register so it maps onto block RAM.
module wave_trig_ram
  import wave_trig_pkg::*;
#(
  parameter int N     = 10,
  parameter int DEPTH = 512,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];
  logic [N-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wave_trigger.sv
// Trigger/capture stage: circular sample buffer, level-crossing trigger, DEPTH-sample window read out
// through a 2-entry skid. Optional auto trigger after AUTO_TIMEOUT armed samples with WAVE_TRIG_AUTO_EN.
module wave_trigger
  import wave_trig_pkg::*;
#(
  parameter int N     = 10,
  parameter int DEPTH = 512,
  parameter int PRE   = 128
`ifdef WAVE_TRIG_AUTO_EN
  ,
  parameter int AUTO_TIMEOUT = 65535
`endif
) (
  input  logic         clkSmpl,
  input  logic         n_reset,
  input  logic         smpl_en,
  input  logic [N-1:0] smpl,
  input  logic [N-1:0] level,
  input  logic         falling,
  input  logic         arm,
  input  logic         force_trig,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         triggered
);

  localparam int AW = ptr_w(DEPTH);

  state_e        state_q, state_d;
  edge_e         edge_q, edge_d;
  logic [AW-1:0] wp_q, wp_d, tp_q, tp_d, cnt_q, cnt_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   issue_cnt_q, issue_cnt_d;
  logic [N-1:0]  level_q, level_d, prev_q, prev_d;
  logic [N-1:0]  ent0_q, ent0_d, ent1_q, ent1_d;
  logic          prev_vld_q, prev_vld_d, triggered_q, triggered_d;
  logic          inflight_q, inflight_d, inflight_last_q, inflight_last_d;
  logic          last0_q, last0_d, last1_q, last1_d;
  logic [1:0]    occ_q, occ_d;

  logic          wr_en, trig_hit, auto_hit, pop, issue;
  logic [2:0]    fill_lvl;
  logic [N-1:0]  ram_rdata;

`ifdef WAVE_TRIG_AUTO_EN
  localparam int ACW = $clog2(AUTO_TIMEOUT + 1);
  logic [ACW-1:0] auto_cnt_q, auto_cnt_d;
`endif

  assign wr_en = smpl_en && (state_q == ST_PRE || state_q == ST_ARMED || state_q == ST_POST);
  assign pop   = out_valid && out_ready;
  // Credits: entries held plus the read in flight, after this cycle's pop, must fit the 2-entry skid.
  assign fill_lvl = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue    = (state_q == ST_READ) && (issue_cnt_q != (AW+1)'(DEPTH)) && (fill_lvl < 3'd2);

  always_comb begin
    trig_hit = 1'b0;
    if (prev_vld_q) begin
      if (edge_q == EDGE_RISING) trig_hit = (prev_q < level_q) && (smpl >= level_q);
      else                       trig_hit = (prev_q > level_q) && (smpl <= level_q);
    end
  end

  always_comb begin
    state_d         = state_q;
    edge_d          = edge_q;
    wp_d            = wp_q;
    tp_d            = tp_q;
    cnt_d           = cnt_q;
    rd_ptr_d        = rd_ptr_q;
    issue_cnt_d     = issue_cnt_q;
    level_d         = level_q;
    prev_d          = prev_q;
    prev_vld_d      = prev_vld_q;
    triggered_d     = triggered_q;
    inflight_d      = issue;
    inflight_last_d = issue && (issue_cnt_q == (AW+1)'(DEPTH - 1));
    auto_hit        = 1'b0;
`ifdef WAVE_TRIG_AUTO_EN
    auto_cnt_d      = auto_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          level_d     = level;
          edge_d      = edge_e'(falling);
          triggered_d = 1'b0;
          cnt_d       = '0;
          prev_vld_d  = 1'b0;
          state_d     = ST_PRE;
`ifdef WAVE_TRIG_AUTO_EN
          auto_cnt_d  = '0;
`endif
        end
      end
      ST_PRE: begin
        if (smpl_en) begin
          if (cnt_q == AW'(PRE - 1)) begin
            cnt_d   = '0;
            state_d = ST_ARMED;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      ST_ARMED: begin
        if (smpl_en) begin
`ifdef WAVE_TRIG_AUTO_EN
          auto_hit   = (auto_cnt_q == ACW'(AUTO_TIMEOUT - 1));
          auto_cnt_d = auto_cnt_q + ACW'(1);
`endif
          if (trig_hit || force_trig || auto_hit) begin
            tp_d    = wp_q;
            cnt_d   = '0;
            state_d = ST_POST;
            // An auto trigger leaves triggered low so the display can flag free-run.
            if (trig_hit || force_trig) triggered_d = 1'b1;
          end
        end
      end
      ST_POST: begin
        if (smpl_en) begin
          if (cnt_q == AW'(DEPTH - PRE - 2)) begin
            state_d     = ST_READ;
            rd_ptr_d    = tp_q - AW'(PRE);
            issue_cnt_d = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      ST_READ: begin
        if (pop && last0_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_en) begin
      wp_d       = wp_q + AW'(1);
      prev_d     = smpl;
      prev_vld_d = 1'b1;
    end
    if (issue) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      issue_cnt_d = issue_cnt_q + (AW+1)'(1);
    end
  end

  // Skid: ent0 is the presented beat, ent1 holds a read that landed while the head was stalled.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    occ_d   = occ_q;
    case ({inflight_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          ent0_d  = ram_rdata;
          last0_d = inflight_last_q;
        end else begin
          ent1_d  = ram_rdata;
          last1_d = inflight_last_q;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        last0_d = last1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          ent0_d  = ram_rdata;
          last0_d = inflight_last_q;
        end else begin
          ent0_d  = ent1_q;
          last0_d = last1_q;
          ent1_d  = ram_rdata;
          last1_d = inflight_last_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkSmpl or negedge n_reset) begin
    if (!n_reset) begin
      state_q         <= ST_IDLE;
      edge_q          <= EDGE_RISING;
      wp_q            <= '0;
      tp_q            <= '0;
      cnt_q           <= '0;
      rd_ptr_q        <= '0;
      issue_cnt_q     <= '0;
      level_q         <= '0;
      prev_q          <= '0;
      prev_vld_q      <= 1'b0;
      triggered_q     <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      ent0_q          <= '0;
      ent1_q          <= '0;
      last0_q         <= 1'b0;
      last1_q         <= 1'b0;
      occ_q           <= '0;
`ifdef WAVE_TRIG_AUTO_EN
      auto_cnt_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      edge_q          <= edge_d;
      wp_q            <= wp_d;
      tp_q            <= tp_d;
      cnt_q           <= cnt_d;
      rd_ptr_q        <= rd_ptr_d;
      issue_cnt_q     <= issue_cnt_d;
      level_q         <= level_d;
      prev_q          <= prev_d;
      prev_vld_q      <= prev_vld_d;
      triggered_q     <= triggered_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      ent0_q          <= ent0_d;
      ent1_q          <= ent1_d;
      last0_q         <= last0_d;
      last1_q         <= last1_d;
      occ_q           <= occ_d;
`ifdef WAVE_TRIG_AUTO_EN
      auto_cnt_q      <= auto_cnt_d;
`endif
    end
  end

  wave_trig_ram #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clkSmpl),
    .we    (wr_en),
    .waddr (wp_q),
    .wdata (smpl),
    .re    (issue),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign out_valid = (occ_q != 2'd0);
  assign out_last  = out_valid && last0_q;
  assign out_data  = ent0_q;
  assign busy      = (state_q != ST_IDLE);
  assign triggered = triggered_q;

endmodule

// File: tb/tb_wave_trigger.sv
// Directed bench for wave_trigger with N=10, DEPTH=16, PRE=4; auto-trigger case follows WAVE_TRIG_AUTO_EN.
module tb_wave_trigger;

  localparam int N     = 10;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;

  logic         clk = 1'b0;
  logic         n_reset;
  logic         smpl_en;
  logic [N-1:0] smpl;
  logic [N-1:0] level;
  logic         falling;
  logic         arm;
  logic         force_trig;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         triggered;

  int checks   = 0;
  int failures = 0;
  int gen_base, gen_step, gen_k;
  int exp_win [DEPTH];

  always #5 clk = ~clk;

  wave_trigger #(
    .N(N), .DEPTH(DEPTH), .PRE(PRE)
`ifdef WAVE_TRIG_AUTO_EN
    , .AUTO_TIMEOUT(8)
`endif
  ) dut (
    .clkSmpl(clk), .n_reset(n_reset), .smpl_en(smpl_en), .smpl(smpl),
    .level(level), .falling(falling), .arm(arm), .force_trig(force_trig),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .triggered(triggered)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; inputs and checks happen 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    gen_k++;
    smpl = N'(gen_base + gen_step * gen_k);
  endtask

  task automatic set_wave(input int base, input int stp);
    gen_base = base;
    gen_step = stp;
    gen_k    = 0;
    smpl     = N'(base);
  endtask

  task automatic do_arm(input int lvl, input bit fall);
    level   = N'(lvl);
    falling = fall;
    arm     = 1'b1;
    step();
    arm     = 1'b0;
  endtask

  task automatic fill_exp(input int base, input int stp);
    for (int i = 0; i < DEPTH; i++) exp_win[i] = base + stp * i;
  endtask

  task automatic read_window(input bit bp, input string tag);
    int beats, bad, badlast, first, lastc;
    beats = 0; bad = 0; badlast = 0; first = -1; lastc = -1;
    for (int c = 0; c < 400 && beats < DEPTH; c++) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        if (first < 0) first = c;
        if (int'(out_data) != exp_win[beats]) bad++;
        if (out_last != (beats == DEPTH - 1)) badlast++;
        if (out_ready) begin
          beats++;
          if (beats == DEPTH) lastc = c;
        end
      end
      step();
    end
    out_ready = 1'b1;
    check({tag, "_beats"}, beats, DEPTH);
    check({tag, "_data_errs"}, bad, 0);
    check({tag, "_last_errs"}, badlast, 0);
    if (!bp) check({tag, "_gapless"}, lastc - first, DEPTH - 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    n_reset = 1'b0; smpl_en = 1'b1; level = '0; falling = 1'b0;
    arm = 1'b0; force_trig = 1'b0; out_ready = 1'b1;
    set_wave(0, 0);
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_trig", triggered, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    n_reset = 1'b1;
    step();

    // Rising crossing at 100 on a 0,10,20,... ramp.
    set_wave(0, 10);
    do_arm(100, 1'b0);
    check("rise_busy_rise", busy, 1);
    fill_exp(60, 10);
    read_window(1'b0, "rise");
    check("rise_trig", triggered, 1);

    // Falling crossing at 500 on a descending ramp.
    set_wave(1000, -10);
    do_arm(500, 1'b1);
    fill_exp(540, -10);
    read_window(1'b0, "fall");
    check("fall_trig", triggered, 1);

    // Same rising capture under random backpressure.
    set_wave(0, 10);
    do_arm(100, 1'b0);
    fill_exp(60, 10);
    read_window(1'b1, "bp");
    check("bp_trig", triggered, 1);

    // Flat input, force in PRE ignored, force in ARMED triggers, arm in READ ignored.
    set_wave(300, 0);
    do_arm(500, 1'b0);
    force_trig = 1'b1;
    step();
    force_trig = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("force_pre_ignored", triggered, 0);
    check("force_armed_busy", busy, 1);
    force_trig = 1'b1;
    step();
    force_trig = 1'b0;
    check("force_trig", triggered, 1);
    out_ready = 1'b0;
    for (int c = 0; c < 100 && !out_valid; c++) step();
    check("force_rd_valid", out_valid, 1);
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("arm_in_read_busy", busy, 1);
    fill_exp(300, 0);
    read_window(1'b0, "force");
    step();
    check("arm_in_read_idle", busy, 0);

    // Asynchronous reset during POST, then a clean capture.
    set_wave(0, 10);
    do_arm(100, 1'b0);
    for (int c = 0; c < 100 && !triggered; c++) step();
    check("rst_mid_trig_seen", triggered, 1);
    step(); step();
    #2;
    n_reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_trig", triggered, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_data", out_data, 0);
    step();
    n_reset = 1'b1;
    step();
    set_wave(0, 10);
    do_arm(100, 1'b0);
    fill_exp(60, 10);
    read_window(1'b0, "post_rst");
    check("post_rst_trig", triggered, 1);

    // Flat input with no crossing: auto trigger when enabled, otherwise waits indefinitely.
    set_wave(300, 0);
    do_arm(500, 1'b0);
`ifdef WAVE_TRIG_AUTO_EN
    begin
      int lat;
      lat = 0;
      while (lat < 200 && !out_valid) begin
        step();
        lat++;
      end
      check("auto_latency", lat, 25);
      check("auto_trig_low", triggered, 0);
      fill_exp(300, 0);
      read_window(1'b0, "auto");
    end
`else
    for (int i = 0; i < 1000; i++) step();
    check("noauto_busy", busy, 1);
    check("noauto_trig", triggered, 0);
    check("noauto_valid", out_valid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
